axis_bit_xcorr: RTL and testbench
=================================

// Module: axis_bit_xcorr
// PURPOSE
// - Bit-coefficient (+1/-1) correlator with AXI-stream in and out; one multiplier-free transposed-form filter per lane.
// - Each slave beat carries NUM_PARALLEL independent channels.
// - Channels are processed serially, one lane per clock, through one shared adder chain; per-channel chain state is held in small memories.
// - Sits after the ADC sample packer, ahead of the peak detector.
// PARAMETERS
// - NUM_PARALLEL      8        channels per beat; power of 2, >=2
// - SLAVE_WIDTH       64       s_axis_tdata width; WAVE_WIDTH = SLAVE_WIDTH/NUM_PARALLEL
// - MASTER_WIDTH      128      m_axis_tdata width; FILT_WIDTH = MASTER_WIDTH/NUM_PARALLEL; FILT_WIDTH >= ADDER_WIDTH
// - ADDER_WIDTH       12       internal accumulator width (signed)
// - CORR_LENGTH       4        number of taps L
// - COEFFS            4'b1011  tap bits; bit j = 1 means +1, 0 means -1
// - SHIFT_DEPTH       1        input/address pipeline depth (>=1) for timing
// - USE_STALL_SIGNAL  1        1 = stall input while a result waits behind a held output
// PORTS
// - clk            in   1        single clock
// - rst_n          in   1        asynchronous reset, active-low
// - s_axis_tvalid  in   1        input beat valid
// - s_axis_tready  out  1        input beat accepted (last-lane cycle)
// - s_axis_tdata   in   SLAVE_W  lane n = bits [n*WAVE_WIDTH +: WAVE_WIDTH], signed
// - m_axis_tvalid  out  1        result beat valid
// - m_axis_tready  in   1        downstream ready
// - m_axis_tdata   out  MASTER_W lane n = bits [n*FILT_WIDTH +: FILT_WIDTH], signed
// BEHAVIOUR
// - Reset (rst_n low, async):
//   - lane counter = 0.
//   - All chain memories = 0.
//   - m_axis_tvalid = 0, m_axis_tdata = 0, internal pending flag = 0.
//   - s_axis_tready = 0.
// - Per-channel math: y[k] = sum_{j=0..L-1} c[L-1-j]*x[k-j], where c[i] = COEFFS[i] ? +1 : -1.
// - Per-stage structure:
//   - stage 0 = +/-x.
//   - stage i = mem_i[ch] +/- x, where mem_i[ch] holds stage i-1 from the previous beat of that channel.
//   - Output = stage L-1.
// - Arithmetic:
//   - Input is sign-extended to ADDER_WIDTH.
//   - Adds wrap modulo 2^ADDER_WIDTH.
//   - Result is sign-extended to FILT_WIDTH.
// - Serial processing:
//   - Lane counter advances by 1 per clk while s_axis_tvalid=1 and not stalled.
//   - It holds at NUM_PARALLEL-1; no wrap.
// - Input handshake:
//   - s_axis_tready = (count==NUM_PARALLEL-1) & ~stall.
//   - On handshake the counter returns to 0.
//   - One beat is accepted per NUM_PARALLEL cycles at best.
//   - tdata must stay stable while tvalid=1 (AXI rule); lanes are read before tready rises.
// - Memory addressing:
//   - Write address = count delayed SHIFT_DEPTH.
//   - Read address is one lane ahead, so read data is ready with 1-cycle read latency.
//   - Memories are written only on enabled cycles.
// - Output buffering:
//   - Results of the last stage are written per lane into an output register bank.
//   - When the last lane is written (rising edge of delayed last-lane flag), a pending flag sets.
//   - Pending flag clears when transferred.
// - Output register:
//   - Loads {pending, packed bank} when m_axis_tvalid=0 or m_axis_tready=1; otherwise it holds.
//   - Latency: m_axis_tvalid rises SHIFT_DEPTH+2 clks after the input handshake edge with m_axis_tready=1.
// - Stall:
//   - With USE_STALL_SIGNAL=1, stall = pending & m_axis_tvalid, which freezes the counter and writes.
//   - With USE_STALL_SIGNAL=0, stall = 0 and a held output may be overwritten.
// - Backpressure: m_axis_tdata/tvalid stable while tvalid=1 & tready=0.
// - Reset mid-beat: partial beat discarded, chain state zeroed, counter restarts at lane 0.
// CONFIGURATION
// - AXIS_BIT_XCORR_SAT_EN defined: every stage add/subtract saturates to [-2^(AW-1), 2^(AW-1)-1].
// - Undefined: wrap-around arithmetic as above; no extra logic.
// TESTING
// Defaults unless stated (WAVE_WIDTH=8, FILT_WIDTH=16).
// - Reset: rst_n=0 mid-stream -> m_axis_tvalid=0, m_axis_tdata=0, s_axis_tready=0 immediately.
// - Impulse: beat lane0=1, others 0, then 3 zero beats -> lane0 outputs 0x0001,0xFFFF,0x0001,0x0001; other lanes 0x0000.
// - Negative impulse: lane3=-128 (0x80) -> lane3 outputs 0xFF80,0x0080,0xFF80,0xFF80.
// - Constant: all lanes=5 every beat -> each lane 5,0,5,10, then 10 (0x000A) steady.
// - Throughput: s_axis_tvalid and m_axis_tready held 1 -> one s handshake every 8 clks; m_axis_tvalid pulses once per beat.
// - Backpressure: m_axis_tready=0 for 40 clks with USE_STALL_SIGNAL=1 -> output held; s_axis_tready stays 0 after the second result is pending; release -> all results delivered in order, none lost.

Source files
------------

// File: rtl/axis_bit_xcorr.sv
// axis_bit_xcorr: +1/-1 bit-coefficient transposed-form correlator, NUM_PARALLEL lanes per beat
// processed serially through one shared adder chain; per-lane chain state lives in small memories.
// Latency: m_axis_tvalid rises SHIFT_DEPTH+2 clocks after the input handshake edge (output ready).
// Backpressure: output register holds while tvalid & ~tready; with USE_STALL_SIGNAL=1 a second
// pending result stalls the lane counter and s_axis_tready until the held beat is taken.
// Build option: define AXIS_BIT_XCORR_SAT_EN for saturating stage arithmetic (default wraps).
module axis_bit_xcorr #(
  parameter int                     NUM_PARALLEL     = 8,
  parameter int                     SLAVE_WIDTH      = 64,
  parameter int                     MASTER_WIDTH     = 128,
  parameter int                     ADDER_WIDTH      = 12,
  parameter int                     CORR_LENGTH      = 4,
  parameter logic [CORR_LENGTH-1:0] COEFFS           = 4'b1011,
  parameter int                     SHIFT_DEPTH      = 1,
  parameter int                     USE_STALL_SIGNAL = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [SLAVE_WIDTH-1:0]  s_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [MASTER_WIDTH-1:0] m_axis_tdata
);

  localparam int WW = SLAVE_WIDTH / NUM_PARALLEL;
  localparam int FW = MASTER_WIDTH / NUM_PARALLEL;
  localparam int AW = ADDER_WIDTH;
  localparam int CW = $clog2(NUM_PARALLEL);
  localparam logic [CW-1:0] LAST_LANE = CW'(NUM_PARALLEL - 1);

  // Signed add/subtract of two AW-bit values; wraps unless the saturating build is selected.
  function automatic logic [AW-1:0] addsub(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                           input logic sub);
    logic [AW:0] s;
    s = sub ? ({a[AW-1], a} - {b[AW-1], b}) : ({a[AW-1], a} + {b[AW-1], b});
`ifdef AXIS_BIT_XCORR_SAT_EN
    if (s[AW] != s[AW-1]) begin
      return s[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end
`endif
    return s[AW-1:0];
  endfunction

  logic [CW-1:0]          count;
  logic                   pending;
  logic                   stall;
  logic                   en;
  logic                   load;
  logic [WW-1:0]          lane_dat;
  logic [CW-1:0]          cnt_p [SHIFT_DEPTH];
  logic [WW-1:0]          dat_p [SHIFT_DEPTH];
  logic [SHIFT_DEPTH-1:0] en_p;
  logic [CW-1:0]          rd_addr;
  logic [CW-1:0]          wr_addr;
  logic                   wr_en;
  logic                   wr_last;
  logic [AW-1:0]          x_ext;
  logic [AW-1:0]          mem   [1:CORR_LENGTH-1][NUM_PARALLEL];
  logic [AW-1:0]          rd_q  [1:CORR_LENGTH-1];
  logic [AW-1:0]          stage [CORR_LENGTH];
  logic [AW-1:0]          bank  [NUM_PARALLEL];
  logic [MASTER_WIDTH-1:0] res_next;
  logic [MASTER_WIDTH-1:0] res_q;
  logic                   last_d;
  logic                   last_dd;

  // Stall only blocks new lanes from entering; lanes already in flight still complete.
  assign stall         = (USE_STALL_SIGNAL != 0) && pending && m_axis_tvalid;
  assign en            = s_axis_tvalid && !stall;
  assign s_axis_tready = (count == LAST_LANE) && !stall;
  assign load          = !m_axis_tvalid || m_axis_tready;
  assign lane_dat      = s_axis_tdata[count*WW +: WW];

  // Lane counter: one lane per enabled clock, parks on the last lane until the beat is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST_LANE) ? '0 : count + 1'b1;
    end
  end

  // Timing pipeline carrying lane index, lane sample and enable towards the adder chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SHIFT_DEPTH; k++) begin
        cnt_p[k] <= '0;
        dat_p[k] <= '0;
      end
      en_p <= '0;
    end else begin
      cnt_p[0] <= count;
      dat_p[0] <= lane_dat;
      en_p[0]  <= en;
      for (int k = 1; k < SHIFT_DEPTH; k++) begin
        cnt_p[k] <= cnt_p[k-1];
        dat_p[k] <= dat_p[k-1];
        en_p[k]  <= en_p[k-1];
      end
    end
  end

  // Read one pipeline stage ahead of the write stage so registered read data lines up.
  if (SHIFT_DEPTH == 1) begin : g_rd_direct
    assign rd_addr = count;
  end else begin : g_rd_piped
    assign rd_addr = cnt_p[SHIFT_DEPTH-2];
  end

  assign wr_addr = cnt_p[SHIFT_DEPTH-1];
  assign wr_en   = en_p[SHIFT_DEPTH-1];
  assign wr_last = wr_en && (wr_addr == LAST_LANE);
  assign x_ext   = AW'($signed(dat_p[SHIFT_DEPTH-1]));

  // Shared transposed-form chain: stage i adds or subtracts x according to tap bit i.
  always_comb begin
    stage[0] = addsub('0, x_ext, !COEFFS[0]);
    for (int i = 1; i < CORR_LENGTH; i++) begin
      stage[i] = addsub(rd_q[i], x_ext, !COEFFS[i]);
    end
  end

  // Per-lane chain memories: registered read every clock, write only on enabled lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < CORR_LENGTH; i++) begin
        rd_q[i] <= '0;
        for (int n = 0; n < NUM_PARALLEL; n++) mem[i][n] <= '0;
      end
    end else begin
      for (int i = 1; i < CORR_LENGTH; i++) begin
        rd_q[i] <= mem[i][rd_addr];
        if (wr_en) mem[i][wr_addr] <= stage[i-1];
      end
    end
  end

  // Packed, sign-extended result with the last lane taken straight from the chain output.
  always_comb begin
    logic [AW-1:0] val;
    val      = '0;
    res_next = '0;
    for (int n = 0; n < NUM_PARALLEL; n++) begin
      val = (n == NUM_PARALLEL - 1) ? stage[CORR_LENGTH-1] : bank[n];
      res_next[n*FW +: FW] = FW'($signed(val));
    end
  end

  // Result bank per lane; a completed beat is snapshotted so the next beat can refill the bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NUM_PARALLEL; n++) bank[n] <= '0;
      res_q   <= '0;
      last_d  <= 1'b0;
      last_dd <= 1'b0;
    end else begin
      if (wr_en) bank[wr_addr] <= stage[CORR_LENGTH-1];
      if (wr_last) res_q <= res_next;
      last_d  <= wr_last;
      last_dd <= last_d;
    end
  end

  // Pending flag and output register: a new pending result beats a same-cycle transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending       <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      if (last_d && !last_dd) begin
        pending <= 1'b1;
      end else if (load) begin
        pending <= 1'b0;
      end
      if (load) begin
        m_axis_tvalid <= pending;
        m_axis_tdata  <= res_q;
      end
    end
  end

endmodule

// File: tb/tb_axis_bit_xcorr.sv
// Bench for axis_bit_xcorr: directed impulse/constant vectors plus randomized traffic,
// all outputs scored against a direct-convolution reference model kept here.
module tb_axis_bit_xcorr;

  localparam int NP = 8;
  localparam int SW = 64;
  localparam int MW = 128;
  localparam int AW = 12;
  localparam int L  = 4;
  localparam int SD = 1;
  localparam int WW = SW / NP;
  localparam int FW = MW / NP;
  localparam logic [L-1:0] CO = 4'b1011;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [SW-1:0] s_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [MW-1:0] m_axis_tdata;

  always #5 clk = ~clk;

  axis_bit_xcorr #(
    .NUM_PARALLEL(NP), .SLAVE_WIDTH(SW), .MASTER_WIDTH(MW), .ADDER_WIDTH(AW),
    .CORR_LENGTH(L), .COEFFS(CO), .SHIFT_DEPTH(SD), .USE_STALL_SIGNAL(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata)
  );

  int n_err = 0;
  int n_chk = 0;

  int            hist [NP][$];
  logic [MW-1:0] exp_q [$];
  logic [MW-1:0] rx_q [$];
  logic [SW-1:0] src_q [$];

  int            vld_pct = 100;
  int            rdy_pct = 100;
  int            cyc = 0;
  int            hs_cnt = 0;
  int            last_hs_cyc = 0;
  bit            chk_tp = 0;
  bit            prev_mv = 0;
  bit            held = 0;
  logic [MW-1:0] held_dat;

  logic [15:0] imp_lane0 [4] = '{16'h0001, 16'hFFFF, 16'h0001, 16'h0001};
  logic [15:0] neg_lane3 [4] = '{16'hFF80, 16'h0080, 16'hFF80, 16'hFF80};
  logic [15:0] cst_lane  [5] = '{16'h0005, 16'h0000, 16'h0005, 16'h000A, 16'h000A};

  task automatic check(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: y[k] = sum_j c[L-1-j]*x[k-j], wrapped to AW bits, sign-extended to FW.
  task automatic model_accept(input logic [SW-1:0] d);
    logic [L-1:0]  co;
    logic [MW-1:0] e;
    logic [AW-1:0] yw;
    int            x;
    int            y;
    co = CO;
    e  = '0;
    for (int n = 0; n < NP; n++) begin
      x = int'($signed(d[n*WW +: WW]));
      hist[n].push_front(x);
      if (hist[n].size() > L) hist[n].delete(L);
      y = 0;
      for (int j = 0; j < hist[n].size(); j++) begin
        y += co[L-1-j] ? hist[n][j] : -hist[n][j];
      end
      yw = y[AW-1:0];
      e[n*FW +: FW] = {{(FW-AW){yw[AW-1]}}, yw};
    end
    exp_q.push_back(e);
  endtask

  // One clock: observe at the falling edge, then update drivers just after the rising edge.
  task automatic cycle();
    bit acc;
    @(negedge clk);
    cyc++;
    if (held) begin
      check("hold_vld", MW'(m_axis_tvalid), MW'(1));
      check("hold_dat", m_axis_tdata, held_dat);
    end
    if (chk_tp && m_axis_tvalid) begin
      check("vld_pulse", MW'(prev_mv), MW'(0));
      // handshake edge follows sample n; rise edge SD+2 clocks later precedes sample n+SD+3
      check("latency", MW'(cyc - last_hs_cyc), MW'(SD + 3));
    end
    prev_mv  = m_axis_tvalid;
    held     = m_axis_tvalid && !m_axis_tready;
    held_dat = m_axis_tdata;
    if (m_axis_tvalid && m_axis_tready) begin
      rx_q.push_back(m_axis_tdata);
      check("exp_avail", MW'(exp_q.size() > 0), MW'(1));
      if (exp_q.size() > 0) check("out_dat", m_axis_tdata, exp_q.pop_front());
    end
    acc = s_axis_tvalid && s_axis_tready;
    if (acc) begin
      if (chk_tp && hs_cnt > 0) check("hs_gap", MW'(cyc - last_hs_cyc), MW'(NP));
      hs_cnt++;
      last_hs_cyc = cyc;
      model_accept(s_axis_tdata);
      if (src_q.size() > 0) src_q.delete(0);
    end
    @(posedge clk);
    #1;
    if (acc) s_axis_tvalid = 1'b0;
    if (!s_axis_tvalid && src_q.size() > 0 && $urandom_range(99) < vld_pct) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = src_q[0];
    end
    m_axis_tready = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_tvalid", MW'(m_axis_tvalid), MW'(0));
    check("rst_tdata", m_axis_tdata, MW'(0));
    check("rst_tready", MW'(s_axis_tready), MW'(0));
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b0;
    for (int n = 0; n < NP; n++) hist[n].delete();
    exp_q.delete();
    src_q.delete();
    rx_q.delete();
    hs_cnt  = 0;
    held    = 0;
    prev_mv = 0;
    chk_tp  = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0) && k < budget) begin
      cycle();
      k++;
    end
    check("drain_left", MW'(src_q.size() + exp_q.size()), MW'(0));
  endtask

  initial begin
    logic [MW-1:0] e;
    int            k;
    rst_n         = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b0;
    #2;
    do_reset();

    // impulse on lane 0
    vld_pct = 100;
    rdy_pct = 100;
    src_q.push_back(64'h1);
    repeat (3) src_q.push_back(64'h0);
    drain(200);
    check("imp_cnt", MW'(rx_q.size()), MW'(4));
    for (int b = 0; b < rx_q.size() && b < 4; b++) begin
      e = '0;
      e[15:0] = imp_lane0[b];
      check($sformatf("imp_b%0d", b), rx_q[b], e);
    end

    // negative full-scale impulse on lane 3
    do_reset();
    src_q.push_back(64'h0000_0000_8000_0000);
    repeat (3) src_q.push_back(64'h0);
    drain(200);
    check("neg_cnt", MW'(rx_q.size()), MW'(4));
    for (int b = 0; b < rx_q.size() && b < 4; b++) begin
      e = '0;
      e[63:48] = neg_lane3[b];
      check($sformatf("neg_b%0d", b), rx_q[b], e);
    end

    // reset in the middle of traffic with a result on the output
    do_reset();
    rdy_pct = 30;
    repeat (20) src_q.push_back({$urandom, $urandom});
    k = 0;
    while (!(m_axis_tvalid && hs_cnt >= 3) && k < 300) begin
      cycle();
      k++;
    end
    check("mid_vld_seen", MW'(m_axis_tvalid), MW'(1));
    do_reset();

    // constant input straight after the mid-stream reset: chain state must start from zero
    rdy_pct = 100;
    repeat (5) src_q.push_back({8{8'h05}});
    drain(300);
    check("cst_cnt", MW'(rx_q.size()), MW'(5));
    for (int b = 0; b < rx_q.size() && b < 5; b++) begin
      check($sformatf("cst_b%0d", b), rx_q[b], {8{cst_lane[b]}});
    end

    // full-rate throughput, latency and pulse shape
    do_reset();
    chk_tp = 1;
    repeat (10) src_q.push_back({$urandom, $urandom});
    drain(300);
    check("tp_hs", MW'(hs_cnt), MW'(10));
    check("tp_out", MW'(rx_q.size()), MW'(10));
    chk_tp = 0;

    // sustained backpressure: second result pending stalls the input
    do_reset();
    rdy_pct = 0;
    repeat (6) src_q.push_back({$urandom, $urandom});
    repeat (40) cycle();
    check("bp_tready", MW'(s_axis_tready), MW'(0));
    check("bp_hs", MW'(hs_cnt), MW'(2));
    check("bp_vld", MW'(m_axis_tvalid), MW'(1));
    rdy_pct = 100;
    drain(500);
    check("bp_out", MW'(rx_q.size()), MW'(6));

    // random valid/ready traffic
    do_reset();
    vld_pct = 70;
    rdy_pct = 60;
    repeat (60) src_q.push_back({$urandom, $urandom});
    drain(3000);
    check("rnd_out", MW'(rx_q.size()), MW'(60));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
